// File: rtl/vector_detect_pkg.sv
// Shared types and constants for the vector_detect family: arbiter FSM
// states, default vector width, index-width helper and detector modes.
package vector_detect_pkg;

    // Default number of requesters / vector bits.
    localparam int DEFAULT_VECTOR_WIDTH = 16;

    // Detector modes shared with the existing detector top.
    localparam logic [1:0] DETECT_MODE_LOWEST  = 2'd0;
    localparam logic [1:0] DETECT_MODE_HIGHEST = 2'd1;
    localparam logic [1:0] DETECT_MODE_ANY     = 2'd2;
    localparam logic [1:0] DETECT_MODE_COUNT   = 2'd3;

    // Round-robin arbiter states.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vector_detect_lowest.sv
// Combinational lowest-set-bit detector: one-hot of the lowest set bit,
// its index, and a flag saying whether any bit was set.
module vector_detect_lowest
    import vector_detect_pkg::*;
#(
    parameter int WIDTH = DEFAULT_VECTOR_WIDTH,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan upward and latch the first set bit encountered.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_vec[i] && !o_found) begin
                o_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vector_rr_arbiter.sv
// Round-robin arbiter with a hold budget. Requests are masked by a rotating
// priority pointer; the lowest set bit of the masked vector wins, falling
// back to the lowest set bit of the raw vector. Grant and index are
// registered and held until the owner drops or the hold budget expires.
module vector_rr_arbiter
    import vector_detect_pkg::*;
#(
    parameter int VECTOR_WIDTH = DEFAULT_VECTOR_WIDTH,
    parameter int MAX_HOLD     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [VECTOR_WIDTH-1:0]            req,
    output logic [VECTOR_WIDTH-1:0]            grant,
    output logic                               grant_valid,
    output logic [idx_width(VECTOR_WIDTH)-1:0] grant_idx
);

    localparam int IDX_W = idx_width(VECTOR_WIDTH);
    localparam int CNT_W = idx_width(MAX_HOLD + 1);

    localparam bit              HOLD_LIMITED = (MAX_HOLD != 0);
    localparam int              HOLD_LAST_I  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(VECTOR_WIDTH - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [VECTOR_WIDTH-1:0] r_grant;
    logic [VECTOR_WIDTH-1:0] w_grant_nxt;
    logic                    r_valid;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        w_ptr_nxt;
    logic [CNT_W-1:0]        r_hold_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    logic [VECTOR_WIDTH-1:0] w_mask;
    logic [VECTOR_WIDTH-1:0] w_masked;
    logic [VECTOR_WIDTH-1:0] w_m_onehot;
    logic [VECTOR_WIDTH-1:0] w_r_onehot;
    logic [IDX_W-1:0]        w_m_idx;
    logic [IDX_W-1:0]        w_r_idx;
    logic                    w_m_found;
    logic                    w_r_found;
    logic [VECTOR_WIDTH-1:0] w_win_onehot;
    logic [IDX_W-1:0]        w_win_idx;
    logic                    w_release;
    logic                    w_issue;

    // Priority mask: only bits at or above the pointer stay eligible.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < VECTOR_WIDTH; i++) begin
            w_mask[i] = (IDX_W'(i) >= r_ptr);
        end
    end

    assign w_masked = req & w_mask;

    vector_detect_lowest #(
        .WIDTH (VECTOR_WIDTH),
        .IDX_W (IDX_W)
    ) u_lowest_masked (
        .i_vec    (w_masked),
        .o_onehot (w_m_onehot),
        .o_idx    (w_m_idx),
        .o_found  (w_m_found)
    );

    vector_detect_lowest #(
        .WIDTH (VECTOR_WIDTH),
        .IDX_W (IDX_W)
    ) u_lowest_raw (
        .i_vec    (req),
        .o_onehot (w_r_onehot),
        .o_idx    (w_r_idx),
        .o_found  (w_r_found)
    );

    assign w_win_onehot = w_m_found ? w_m_onehot : w_r_onehot;
    assign w_win_idx    = w_m_found ? w_m_idx    : w_r_idx;

    assign w_release = !req[r_grant_idx] ||
                       (HOLD_LIMITED && (r_hold_cnt == HOLD_LAST));

    // Next-state logic: hold, re-arbitrate without a bubble, or go idle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_grant_idx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_hold_cnt;
        w_issue     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_r_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (w_release) begin
                    if (w_r_found) begin
                        w_issue = 1'b1;
                    end else begin
                        w_grant_nxt = '0;
                        w_state_nxt = ARB_IDLE;
                    end
                end else if (r_hold_cnt != '1) begin
                    w_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ARB_IDLE;
            end
        endcase

        if (w_issue) begin
            w_grant_nxt = w_win_onehot;
            w_idx_nxt   = w_win_idx;
            w_cnt_nxt   = '0;
            w_ptr_nxt   = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
        end
    end

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_valid     <= 1'b0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_valid     <= (w_state_nxt == ARB_GRANT);
            r_grant_idx <= w_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_cnt_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_grant_idx;

endmodule

// File: doc/vector_rr_arbiter.md
# vector_rr_arbiter

Round-robin arbiter that shares one resource between `VECTOR_WIDTH` requesters, built on the lowest-set-bit vector detector datapath. Each cycle it masks the request vector with a rotating priority pointer and picks the lowest set bit. It then holds the grant until the owner drops its request or a hold budget expires. It sits between requester blocks and any shared datapath in the vector_detect family and supplies a registered one-hot grant plus its index.

## Interface
- `VECTOR_WIDTH`, 16: number of requesters; legal range ≥ 2.
- `MAX_HOLD`, 8: maximum consecutive cycles one grant is held; 0 = unlimited.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  VECTOR_WIDTH  request vector; bit i = requester i; level-sensitive.
- `grant`  out  VECTOR_WIDTH  registered one-hot grant, or all-zero.
- `grant_valid`  out  1  registered; equals `|grant`.
- `grant_idx`  out  $clog2(VECTOR_WIDTH)  registered index of the granted bit; holds its last value when `grant_valid`=0.

## Operation
- States: IDLE (no grant) and GRANT (one owner).
- Arbitration, combinational, from current `req` and pointer `ptr`:
  - masked = req AND (bits ≥ ptr).
  - Winner = lowest set bit of masked if masked≠0, else lowest set bit of req.
- IDLE:
  - req=0: stay in IDLE.
  - req≠0: register the winner into `grant`/`grant_idx`, set `grant_valid`=1, hold_cnt←0, go to GRANT.
- GRANT, release condition: `req[grant_idx]`=0, or (`MAX_HOLD`≠0 and hold_cnt = `MAX_HOLD`−1).
  - No release: keep the grant; hold_cnt←hold_cnt+1 (saturate when `MAX_HOLD`=0).
  - Release and req≠0: re-arbitrate in the same edge, issue the new grant with no bubble cycle, hold_cnt←0.
  - Release and req=0: clear `grant` and `grant_valid`, go to IDLE.
- Pointer update on every grant issue to index k: ptr←k+1, wrapping to 0 when k = `VECTOR_WIDTH`−1. The pointer is unchanged otherwise.
- Timeout with the holder as sole requester: the holder is regranted, with a fresh hold_cnt and ptr advanced.
- Timeout with other requesters present: the pointer guarantees a different requester wins.
- Fairness: any continuously asserted request is granted within (`VECTOR_WIDTH`−1)·`MAX_HOLD` cycles when `MAX_HOLD`≠0.

## Timing
- Reset (asynchronous, immediate): `grant`=0, `grant_valid`=0, `grant_idx`=0, ptr=0, hold_cnt=0, state=IDLE. This also applies mid-grant; the first edge after release of `rst_n` behaves as IDLE with ptr=0.
- Latency: `req` sampled at edge e → `grant` visible after edge e (one cycle).
- Release lag: owner drops `req` before edge e → grant moves or clears at edge e.
- Under continuous request, a grant is high for exactly `MAX_HOLD` cycles.
- Requests that rise and fall between edges are not seen.
- Simultaneous release and new requests: the new requests take part in the same-edge re-arbitration.

## Structure
- Package `vector_detect_pkg`:
  - `VECTOR_WIDTH` default constant.
  - `arb_state_t` enum {ARB_IDLE, ARB_GRANT}.
  - Index-width localparam function (`$clog2`).
  - Mode constants shared with the existing detector top.
- Sub-module `vector_detect_lowest`:
  - Parameterised combinational lowest-set-bit detector; outputs a one-hot vector plus index.
  - Instantiated twice, once on masked and once on raw `req`.
- The arbiter proper holds the FSM, pointer, hold counter and output registers.

## Test plan
Bench configuration: `VECTOR_WIDTH`=4, `MAX_HOLD`=3 unless noted.
- Reset mid-grant: owner 2 granted, pulse `rst_n` low → outputs 0 immediately. After release with req=4'b0110, grant=4'b0010 (ptr=0 → lowest bit 1).
- Single requester: req=4'b0100 held for 7 cycles → grant=4'b0100 from cycle 1. Regranted every 3 cycles, continuous, `grant_idx`=2.
- Rotation: req=4'b1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, each for 3 cycles with no gaps.
- Early release: req=4'b0011, owner 0 drops after 1 cycle → grant moves to 4'b0010 on the next edge. Then req=0 → `grant_valid`=0 one edge later.
- Pointer wrap: grant to 3 with req=4'b1001 → next grant 4'b0001 (ptr wrapped to 0).
- `MAX_HOLD`=0: req=4'b0011 held for 20 cycles → grant stays 4'b0001 for all 20 cycles; requester 1 is served only after bit 0 drops.
